// File: rtl/spart_pkg.sv
// SPART transmit shared constants, address map and FSM state type.
// SPART_PARITY_EN adds an even-parity bit before the stop bit.
package spart_pkg;

    localparam int DIV_W  = 16;
    localparam int OVS    = 16;
    localparam int TICK_W = $clog2(OVS);

    localparam logic [1:0] ADDR_TXRX = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// SPART baud generator: bus-writable 16-bit divisor and a reloading
// down-counter that pulses o_en once per divisor+1 clocks.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [DIV_W-1:0] DIV_RESET = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_we,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_data,
    input  logic       i_restart,
    output logic       o_en
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             w_zero;

    assign w_zero = (r_cnt == '0);
    assign o_en   = w_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= DIV_RESET;
        end else if (i_we) begin
            if (i_addr == ADDR_DBL) begin
                r_div[7:0] <= i_data;
            end else if (i_addr == ADDR_DBH) begin
                r_div[15:8] <= i_data;
            end
        end
    end

    // A new divisor only takes effect at the next reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_restart || w_zero) begin
            r_cnt <= r_div;
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: holding register, shift register and 8N1 framing FSM.
// Define SPART_PARITY_EN for an 11-bit frame with an even-parity bit.
module spart_tx
    import spart_pkg::*;
#(
    parameter logic [DIV_W-1:0] DIV_RESET = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] databus,
    output logic       tbr,
    output logic       txd
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [7:0]        r_hold;
    logic [7:0]        r_shift;
    logic              r_full;
    logic [2:0]        r_idx;
    logic [TICK_W-1:0] r_tick;
`ifdef SPART_PARITY_EN
    logic              r_par;
`endif

    logic w_we;
    logic w_wr_tx;
    logic w_en;
    logic w_load;
    logic w_bit_done;

    assign w_we       = iocs && !iorw;
    assign w_wr_tx    = w_we && (ioaddr == ADDR_TXRX) && !r_full;
    assign w_bit_done = w_en && (r_tick == TICK_LAST);
    assign tbr        = !r_full;

    spart_baud_gen #(
        .DIV_RESET (DIV_RESET)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_addr    (ioaddr),
        .i_data    (databus),
        .i_restart (w_load),
        .o_en      (w_en)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_done && (r_idx == 3'd7)) begin
`ifdef SPART_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
`ifdef SPART_PARITY_EN
            PARITY: begin
                if (w_bit_done) begin
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                // Back-to-back frames skip IDLE entirely.
                if (w_bit_done) begin
                    if (r_full) begin
                        w_load      = 1'b1;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= '0;
            r_full <= 1'b0;
        end else if (w_load) begin
            r_full <= 1'b0;
        end else if (w_wr_tx) begin
            r_full <= 1'b1;
            r_hold <= databus;
        end
    end

    // Tick counter wraps at OVS so it is already zero at each bit boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_tick  <= '0;
        end else if (w_load) begin
            r_shift <= r_hold;
            r_idx   <= '0;
            r_tick  <= '0;
        end else if (w_en && (r_state != IDLE)) begin
            r_tick <= r_tick + TICK_W'(1);
            if (w_bit_done && (r_state == DATA)) begin
                r_shift <= r_shift >> 1;
                r_idx   <= r_idx + 3'd1;
            end
        end
    end

`ifdef SPART_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^r_hold;
        end
    end
`endif

    always_comb begin
        txd = 1'b1;
        unique case (r_state)
            START:   txd = 1'b0;
            DATA:    txd = r_shift[0];
`ifdef SPART_PARITY_EN
            PARITY:  txd = r_par;
`endif
            default: txd = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_spart_tx.sv
// Randomized bench for spart_tx against a frame-timing reference model.
// Covers the SPART_PARITY_EN build as well as the default 8N1 build.
module tb_spart_tx;

`ifdef SPART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] databus = 8'h00;
    logic       tbr;
    logic       txd;

    spart_tx dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .tbr     (tbr),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a frame is a fixed-length window of NB bits.
    int         m_div  = 325;
    bit         m_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    logic [7:0] m_cur  = 8'h00;
    int         m_rem  = 0;
    int         m_len  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic fbit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == NB - 1) return 1'b1;
        return ^b;
    endfunction

    function automatic logic m_txd();
        int p;
        if (m_rem == 0) return 1'b1;
        p = m_len - m_rem;
        return fbit(m_cur, p / (16 * (m_div + 1)));
    endfunction

    task automatic m_reset();
        m_div  = 325;
        m_full = 1'b0;
        m_rem  = 0;
    endtask

    task automatic step(input bit chk_en);
        bit wr;
        @(posedge clk);
        wr = iocs && !iorw;
        if (m_full && m_rem <= 1) begin
            m_cur  = m_hold;
            m_len  = NB * 16 * (m_div + 1);
            m_rem  = m_len;
            m_full = 1'b0;
        end else begin
            if (m_rem > 0) m_rem--;
            if (wr && ioaddr == 2'b00 && !m_full) begin
                m_full = 1'b1;
                m_hold = databus;
            end
        end
        if (wr && ioaddr == 2'b10) m_div = (m_div & 32'hFF00) | int'(databus);
        if (wr && ioaddr == 2'b11) m_div = (m_div & 32'h00FF) | (int'(databus) << 8);
        #1;
        if (chk_en) begin
            chk("tbr", {31'd0, tbr}, {31'd0, !m_full});
            chk("txd", {31'd0, txd}, {31'd0, m_txd()});
        end
    endtask

    task automatic cyc(input logic cs, input logic rw, input logic [1:0] a,
                       input logic [7:0] d, input bit chk_en);
        iocs    = cs;
        iorw    = rw;
        ioaddr  = a;
        databus = d;
        step(chk_en);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00, 8'h00, 1'b1);
    endtask

    task automatic set_div(input logic [15:0] dv);
        cyc(1'b1, 1'b0, 2'b10, dv[7:0], 1'b1);
        cyc(1'b1, 1'b0, 2'b11, dv[15:8], 1'b1);
    endtask

    logic [10:0] a5_bits;
    logic        tx_rec [0:229];
    int          ntr;
    int          r;

    initial begin
`ifdef SPART_PARITY_EN
        a5_bits = 11'b101_0100_1010;
`else
        a5_bits = 11'b011_0100_1010;
`endif
        #1;
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_tbr", {31'd0, tbr}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        m_reset();
        idle(8);

        // Default divisor: start bit and d0 each last 16*326 clocks.
        cyc(1'b1, 1'b0, 2'b00, 8'h01, 1'b1);
        idle(2 * 16 * 326 + 8);

        // Asynchronous reset in the middle of a frame.
        rst = 1'b0;
        #1;
        chk("mid_rst_txd", {31'd0, txd}, 32'd1);
        chk("mid_rst_tbr", {31'd0, tbr}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        m_reset();
        idle(40);

        // Divisor 1, byte 0xA5.
        set_div(16'd1);
        cyc(1'b1, 1'b0, 2'b00, 8'hA5, 1'b1);
        chk("a5_tbr_low", {31'd0, tbr}, 32'd0);
        for (int p = 0; p < NB * 32 + 4; p++) begin
            cyc(1'b0, 1'b0, 2'b00, 8'h00, 1'b1);
            if (p % 32 == 16) begin
                chk("a5_bit", {31'd0, txd}, {31'd0, a5_bits[p/32]});
            end
        end

        // Back-to-back with divisor 0; 0xFF must be dropped.
        set_div(16'd0);
        cyc(1'b1, 1'b0, 2'b00, 8'h55, 1'b1);
        idle(1);
        cyc(1'b1, 1'b0, 2'b00, 8'h0F, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 2'b00, 8'hFF, 1'b1);
        idle(2 * NB * 16 + 10);

        // Parity-sensitive bytes.
        cyc(1'b1, 1'b0, 2'b00, 8'h07, 1'b1);
        idle(NB * 16 + 4);
        cyc(1'b1, 1'b0, 2'b00, 8'h03, 1'b1);
        idle(NB * 16 + 4);

        // Divisor 3 -> 0 while d0 is on the line.
        set_div(16'd3);
        cyc(1'b1, 1'b0, 2'b00, 8'h0F, 1'b1);
        for (int p = 0; p < 230; p++) begin
            if (p == 74) begin
                cyc(1'b1, 1'b0, 2'b10, 8'h00, 1'b0);
            end else if (p == 75) begin
                cyc(1'b1, 1'b0, 2'b11, 8'h00, 1'b0);
            end else begin
                cyc(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
            end
            tx_rec[p] = txd;
            if (p == 0) chk("mid_tbr", {31'd0, tbr}, 32'd1);
        end
        chk("mid_p0",   {31'd0, tx_rec[0]},   32'd0);
        chk("mid_p64",  {31'd0, tx_rec[64]},  32'd1);
        chk("mid_p136", {31'd0, tx_rec[136]}, 32'd1);
        chk("mid_p137", {31'd0, tx_rec[137]}, 32'd0);
`ifndef SPART_PARITY_EN
        chk("mid_p200", {31'd0, tx_rec[200]}, 32'd0);
        chk("mid_p201", {31'd0, tx_rec[201]}, 32'd1);
        ntr = 0;
        for (int p = 1; p < 230; p++) if (tx_rec[p] != tx_rec[p-1]) ntr++;
        chk("mid_edges", ntr, 32'd3);
`endif
        idle(0);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
        m_div  = 0;
        m_full = 1'b0;
        m_rem  = 0;
        idle(4);

        // Randomized mix of valid and ignored accesses.
        for (int i = 0; i < 6000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                cyc(1'b1, 1'b0, 2'b00, 8'($urandom), 1'b1);
            end else if (r < 12) begin
                cyc(1'b0, 1'($urandom), 2'($urandom), 8'($urandom), 1'b1);
            end else if (r < 16) begin
                cyc(1'b1, 1'b1, 2'($urandom), 8'($urandom), 1'b1);
            end else if (r < 19) begin
                cyc(1'b1, 1'b0, 2'b01, 8'($urandom), 1'b1);
            end else if (r < 21 && m_rem == 0 && !m_full) begin
                set_div(16'($urandom_range(0, 2)));
            end else begin
                cyc(1'b0, 1'b0, 2'b00, 8'h00, 1'b1);
            end
        end
        idle(NB * 16 * 3 * 2 + 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
